servo_slew_limiter: RTL
=======================

# servo_slew_limiter

Rate-limits the servo angle commands produced by the arm's control logic before they reach the `pwm_generator` instances. Each channel's commanded angle moves toward a latched target by at most `MAX_STEP` degrees per update tick. This prevents jerky steps when a target jumps, for example on motor re-selection or a joystick snap. The block sits directly downstream of the angle registers and directly upstream of the PWM generators.

## Interface
Parameters:
- `NUM_CH`, 6: number of servo channels.
- `TICK_DIV`, 1_000_000: CLOCK_50 cycles per update tick (20 ms at 50 MHz).
- `MAX_STEP`, 2: maximum angle change per channel per tick, in degrees; range 1..ANGLE_MAX.
- `ANGLE_MAX`, 180: upper clamp for targets and outputs.
- `HOME_ANGLE`, 90: reset angle and home angle.

Ports (clock and reset first):
- `CLOCK_50`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `target`  in  8*NUM_CH: packed requested angles; channel k is bits [8k+7:8k].
- `target_we`  in  NUM_CH: per-channel write strobe; latches `target` slice k.
- `hold`  in  1: freezes all outputs while high.
- `home_req`  in  1: one-cycle pulse; sends all channels to `HOME_ANGLE`. Active only with `SLEW_HOME_EN`.
- `angle_out`  out  8*NUM_CH: rate-limited angles, feeding the `pwm_generator` inputs.
- `at_target`  out  NUM_CH: channel k output equals its latched target.
- `busy`  out  1: scan in progress.
- `tick`  out  1: one-cycle update-tick pulse.

## Operation
- Target registers `tgt[k]`:
  - On `target_we[k]`, load `min(target slice k, ANGLE_MAX)`.
  - Writes are accepted in every state, including mid-scan.
- FSM states and transitions:
  - IDLE -> SCAN when `tick` is high and `hold` is low. Channel index `ch` is set to 0.
  - SCAN processes exactly one channel per cycle, then `ch` increments.
  - SCAN -> IDLE after `ch == NUM_CH-1`.
  - A `tick` arriving during SCAN is ignored. This cannot occur while TICK_DIV > NUM_CH.
- Per-channel update in SCAN, with `d = tgt[ch] - out[ch]` as signed 9-bit:
  - If `d > MAX_STEP`, `out += MAX_STEP`.
  - If `d < -MAX_STEP`, `out -= MAX_STEP`.
  - Otherwise `out = tgt[ch]`.
  - Outputs never overshoot and never leave 0..ANGLE_MAX.
- Mid-scan target write:
  - If `target_we[k]` lands on the same cycle that channel k is being scanned, the update uses the pre-write `tgt[k]`.
  - The new target takes effect on the next tick.
- `at_target[k]` is combinational: `out[k] == tgt[k]`.
- `hold`:
  - Sampled only at `tick`.
  - A scan already started always completes.
  - Targets still latch while `hold` is high.
- Reset values (asynchronous):
  - `tgt` and `angle_out` = HOME_ANGLE for all channels.
  - `at_target` = all 1.
  - `busy` = 0, `tick` = 0.
  - FSM in IDLE, tick counter at 0.
  - Reset asserted mid-scan aborts the scan immediately.

## Timing
- Tick counter: counts 0..TICK_DIV-1 and wraps. `tick` is high on the cycle the count equals TICK_DIV-1.
- Scan start: SCAN begins the cycle after `tick`; `busy` is high for exactly NUM_CH cycles.
- Output latency: `angle_out` slice k changes at the clock edge ending the (k+1)-th SCAN cycle, i.e. k+2 cycles after `tick`.
- Target latency: `target_we` -> `tgt` updates in 1 cycle, so `at_target` reflects the write 1 cycle later.
- Worst-case slew: from 0 to 180 with MAX_STEP=2 takes 90 ticks (1.8 s).

## Configuration
- Macro: `SERVO_SLEW_HOME_EN`.
- Defined:
  - `home_req` loads HOME_ANGLE into every `tgt`.
  - It wins over a simultaneous `target_we`.
  - Outputs then ramp home at the normal slew rate.
- Undefined:
  - `home_req` is ignored, with no home logic synthesized.
  - The port remains present so the instantiation is unchanged.

## Structure
- Shared package `servo_pkg`:
  - `ANGLE_W = 8`.
  - Typedef `angle_t` (`logic [7:0]`).
  - FSM enum `slew_state_t {SLEW_IDLE, SLEW_SCAN}`.
- Sub-module `slew_tick_gen`: TICK_DIV counter producing `tick`.
- Channel update: a single shared datapath muxed by `ch`, not NUM_CH parallel copies.

## Test plan
Bench uses TICK_DIV=20, NUM_CH=6, MAX_STEP=2.
- Reset, no writes -> all `angle_out`=90, `at_target`=6'h3F, `busy`=0.
- Write ch0 target 100 -> ch0 reads 92, 94, 96, 98, 100 on successive ticks; `at_target[0]`=1 after the 5th tick; other channels stay at 90.
- Write ch2 target 255 -> clamped to 180; ch2 reaches 180 after 45 ticks and never exceeds it. Write ch3 target 91 -> ch3 reads 91 after 1 tick, with no overshoot.
- `hold` high across 3 ticks with ch1 target 60 -> ch1 stays 90; releasing `hold` resumes at 88, 86, ….
- `target_we[4]` (target 0) on the exact cycle ch4 is scanned -> ch4 unchanged that tick, 88 on the next tick.
- With `SERVO_SLEW_HOME_EN` defined: ch0 at 100, pulse `home_req` together with `target_we[0]`=150 -> `tgt[0]`=90 and ch0 ramps 98, 96, …, 90. Without the macro: `tgt[0]`=150.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types for the servo slew limiter: angle type, scan FSM states and a clamp helper.
package servo_pkg;
    localparam int ANGLE_W = 8;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic {SLEW_IDLE, SLEW_SCAN} slew_state_t;

    function automatic angle_t clamp_angle(input angle_t a, input angle_t lim);
        return (a > lim) ? lim : a;
    endfunction
endpackage

// File: rtl/slew_tick_gen.sv
// Free-running divider: tick is high for one cycle every TICK_DIV clocks.
module slew_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)         cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/servo_slew_limiter.sv
// Per-tick rate limiter for servo angle commands; one shared update datapath scans the channels.
// Define SERVO_SLEW_HOME_EN to let home_req retarget every channel to HOME_ANGLE.
module servo_slew_limiter
    import servo_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int TICK_DIV   = 1_000_000,
    parameter int MAX_STEP   = 2,
    parameter int ANGLE_MAX  = 180,
    parameter int HOME_ANGLE = 90
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic [ANGLE_W*NUM_CH-1:0] target,
    input  logic [NUM_CH-1:0]         target_we,
    input  logic                      hold,
    input  logic                      home_req,
    output logic [ANGLE_W*NUM_CH-1:0] angle_out,
    output logic [NUM_CH-1:0]         at_target,
    output logic                      busy,
    output logic                      tick
);
    localparam int DW   = ANGLE_W + 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_CH - 1);
    localparam angle_t               A_MAX   = angle_t'(ANGLE_MAX);
    localparam angle_t               HOME    = angle_t'(HOME_ANGLE);
    localparam angle_t               STEP    = angle_t'(MAX_STEP);
    localparam logic signed [DW-1:0] STEP_S  = DW'(MAX_STEP);

    angle_t      tgt   [NUM_CH];
    angle_t      out_q [NUM_CH];
    slew_state_t state, state_nxt;
    logic [CH_W-1:0] ch, ch_nxt;
    logic        scan_en;
    logic        home_hit;

    slew_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .tick     (tick)
    );

`ifdef SERVO_SLEW_HOME_EN
    assign home_hit = home_req;
`else
    logic unused_home_req;
    assign unused_home_req = home_req;
    assign home_hit        = 1'b0;
`endif

    // Home request overrides any same-cycle write.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) tgt[k] <= HOME;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (home_hit)          tgt[k] <= HOME;
                else if (target_we[k]) tgt[k] <= clamp_angle(target[ANGLE_W*k +: ANGLE_W], A_MAX);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLEW_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        scan_en   = 1'b0;
        case (state)
            SLEW_IDLE: begin
                if (tick && !hold) begin
                    state_nxt = SLEW_SCAN;
                    ch_nxt    = '0;
                end
            end
            SLEW_SCAN: begin
                scan_en = 1'b1;
                if (ch == LAST_CH) begin
                    state_nxt = SLEW_IDLE;
                    ch_nxt    = '0;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end
            default: state_nxt = SLEW_IDLE;
        endcase
    end

    assign busy = (state == SLEW_SCAN);

    // Shared update: targets are registered, so a same-cycle write is seen only next tick.
    angle_t              cur_tgt, cur_out, upd;
    logic signed [DW-1:0] d;

    assign cur_tgt = tgt[ch];
    assign cur_out = out_q[ch];

    always_comb begin
        d   = $signed({1'b0, cur_tgt}) - $signed({1'b0, cur_out});
        upd = cur_tgt;
        if (d > STEP_S)       upd = cur_out + STEP;
        else if (d < -STEP_S) upd = cur_out - STEP;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) out_q[k] <= HOME;
        end else if (scan_en) begin
            out_q[ch] <= upd;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign angle_out[ANGLE_W*k +: ANGLE_W] = out_q[k];
        assign at_target[k]                    = (out_q[k] == tgt[k]);
    end
endmodule
